// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every bus signal around the shared data-RAM port:
//   cpu_*  : MEM stage side (req/we/addr/wdata in, rdata/stall out)
//   dbg_*  : debug/loader side (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   ram_*  : RAM side (addr/wdata/we out, rdata in)
//
// Modports:
//   slave  : the arbiter's view (requests in, grants and RAM controls out)
//   master : the environment's view (MEM stage, debug requester and RAM)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  ram_rdata,
    output cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output ram_rdata,
    input  cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one data-RAM port between the pipeline MEM stage (priority, zero
// added latency) and a debug/loader requester served in idle cycles.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave carrying the cpu_*, dbg_* and ram_*
//          signal groups
//
// Configuration macro ARB_STARVE_GUARD_EN:
//   defined   - a debug request left waiting STARVE_LIMIT cycles gets one
//               forced slot; the MEM stage is stalled for that one cycle.
//   undefined - strict MEM-stage priority, cpu_stall tied low, debug may
//               starve, STARVE_LIMIT only range-checked.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
  end

  logic          dbg_own;
  logic          stall;

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q,  rdata_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int            CW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_q, force_d;

  // force_q alone does not grant: a withdrawn request simply lets the
  // forced slot lapse, and both counter and flag fall back to zero.
  always_comb begin
    dbg_own = bus.dbg_req && (!bus.cpu_req || force_q);
    stall   = bus.cpu_req && force_q && bus.dbg_req;
    cnt_d   = '0;
    if (bus.dbg_req && !dbg_own) begin
      cnt_d = cnt_q + CW'(1);
    end
    force_d = bus.dbg_req && !dbg_own && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end
`else
  always_comb begin
    dbg_own = bus.dbg_req && !bus.cpu_req;
    stall   = 1'b0;
  end
`endif

  // RAM mux. A stalled CPU write never reaches ram_we because a stall only
  // happens while debug owns the port.
  assign bus.ram_addr  = dbg_own ? bus.dbg_addr  : bus.cpu_addr;
  assign bus.ram_wdata = dbg_own ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.ram_we    = dbg_own ? bus.dbg_we    : (bus.cpu_req && bus.cpu_we);

  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.cpu_stall = stall;
  assign bus.dbg_gnt   = dbg_own;

  // Debug read data is captured from the combinational RAM output in the
  // grant cycle and presented with a one-cycle rvalid pulse.
  always_comb begin
    rvalid_d = dbg_own && !bus.dbg_we;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SL = 8;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic fill = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge.
  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];

  function automatic logic [15:0] pat(int i);
    return 16'(i * 263) ^ 16'h5A5A;
  endfunction

  assign bus.ram_rdata = mem[bus.ram_addr[7:0]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
  end

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst  = 1'b0;
    fill = 1'b1;
    step();
    fill = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.cpu_addr = 16'h00AB;
    rst  = 1'b0;
    fill = 1'b1;
    step();
    #1;
    total += 6;
    if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b exp=0", bus.dbg_gnt); end
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", bus.cpu_stall); end
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%0b exp=0", bus.ram_we); end
    if (bus.ram_addr !== 16'h00AB) begin bad++; $display("FAIL rst_ram_addr got=%h exp=00ab", bus.ram_addr); end
    if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", bus.dbg_rvalid); end
    if (bus.dbg_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", bus.dbg_rdata); end
    step();
    fill = 1'b0;
    rst  = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
  endtask

  task automatic test_cpu_write();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h1234;
    #2;
    total += 5;
    if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL cw_ram_we got=%0b exp=1", bus.ram_we); end
    if (bus.ram_addr !== 16'h0020) begin bad++; $display("FAIL cw_ram_addr got=%h exp=0020", bus.ram_addr); end
    if (bus.ram_wdata !== 16'h1234) begin bad++; $display("FAIL cw_ram_wdata got=%h exp=1234", bus.ram_wdata); end
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL cw_stall got=%0b exp=0", bus.cpu_stall); end
    if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL cw_gnt got=%0b exp=0", bus.dbg_gnt); end
    step();
    bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    step();
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    #2;
    total += 2;
    if (bus.cpu_rdata !== 16'h1234) begin bad++; $display("FAIL cr_rdata got=%h exp=1234", bus.cpu_rdata); end
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL cr_ram_we got=%0b exp=0", bus.ram_we); end
    step();
    idle_inputs();
  endtask

  task automatic test_dbg_read();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010;
    #2;
    total += 4;
    if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL dr_gnt got=%0b exp=1", bus.dbg_gnt); end
    if (bus.ram_addr !== 16'h0010) begin bad++; $display("FAIL dr_ram_addr got=%h exp=0010", bus.ram_addr); end
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL dr_ram_we got=%0b exp=0", bus.ram_we); end
    if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dr_rvalid0 got=%0b exp=0", bus.dbg_rvalid); end
    step();
    bus.dbg_req = 1'b0;
    #2;
    total += 2;
    if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid1 got=%0b exp=1", bus.dbg_rvalid); end
    if (bus.dbg_rdata !== 16'hBEEF) begin bad++; $display("FAIL dr_rdata got=%h exp=beef", bus.dbg_rdata); end
    step();
    // debug write: granted, no rvalid afterwards, data lands in RAM
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0050; bus.dbg_wdata = 16'h7777;
    #2;
    total += 4;
    if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dr_rvalid2 got=%0b exp=0", bus.dbg_rvalid); end
    if (bus.dbg_rdata !== 16'hBEEF) begin bad++; $display("FAIL dr_rdata_hold got=%h exp=beef", bus.dbg_rdata); end
    if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL dw_gnt got=%0b exp=1", bus.dbg_gnt); end
    if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL dw_ram_we got=%0b exp=1", bus.ram_we); end
    step();
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0050;
    #2;
    total += 2;
    if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dw_rvalid got=%0b exp=0", bus.dbg_rvalid); end
    if (bus.cpu_rdata !== 16'h7777) begin bad++; $display("FAIL dw_readback got=%h exp=7777", bus.cpu_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_starvation();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0060;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0030; bus.dbg_wdata = 16'h5555;
`ifdef ARB_STARVE_GUARD_EN
    for (int c = 0; c < SL; c++) begin
      #2;
      total += 2;
      if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL sv_gnt cyc=%0d got=%0b exp=0", c, bus.dbg_gnt); end
      if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL sv_stall cyc=%0d got=%0b exp=0", c, bus.cpu_stall); end
      step();
    end
    #2;
    total += 5;
    if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL sv_force_gnt got=%0b exp=1", bus.dbg_gnt); end
    if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL sv_force_stall got=%0b exp=1", bus.cpu_stall); end
    if (bus.ram_addr !== 16'h0030) begin bad++; $display("FAIL sv_ram_addr got=%h exp=0030", bus.ram_addr); end
    if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL sv_ram_we got=%0b exp=1", bus.ram_we); end
    if (bus.ram_wdata !== 16'h5555) begin bad++; $display("FAIL sv_ram_wdata got=%h exp=5555", bus.ram_wdata); end
    step();
    bus.dbg_req = 1'b0;
    #2;
    total += 2;
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL sv_after_stall got=%0b exp=0", bus.cpu_stall); end
    if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL sv_after_gnt got=%0b exp=0", bus.dbg_gnt); end
    step();
    bus.cpu_addr = 16'h0030;
    #2;
    total += 1;
    if (bus.cpu_rdata !== 16'h5555) begin bad++; $display("FAIL sv_readback got=%h exp=5555", bus.cpu_rdata); end
    step();
`else
    for (int c = 0; c < 50; c++) begin
      #2;
      total += 2;
      if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL ng_gnt cyc=%0d got=%0b exp=0", c, bus.dbg_gnt); end
      if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL ng_stall cyc=%0d got=%0b exp=0", c, bus.cpu_stall); end
      step();
    end
    bus.cpu_req = 1'b0;
    #2;
    total += 2;
    if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL ng_idle_gnt got=%0b exp=1", bus.dbg_gnt); end
    if (bus.ram_addr !== 16'h0030) begin bad++; $display("FAIL ng_ram_addr got=%h exp=0030", bus.ram_addr); end
    step();
`endif
    idle_inputs();
  endtask

  task automatic test_withdraw();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0061;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0031;
`ifdef ARB_STARVE_GUARD_EN
    for (int c = 0; c < SL; c++) step();
    bus.dbg_req = 1'b0;
    #2;
    total += 2;
    if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL wd_gnt got=%0b exp=0", bus.dbg_gnt); end
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL wd_stall got=%0b exp=0", bus.cpu_stall); end
    step();
    // fresh wait must take the full STARVE_LIMIT cycles again
    bus.dbg_req = 1'b1;
    for (int c = 0; c <= SL; c++) begin
      #2;
      total += 1;
      if (bus.dbg_gnt !== (c == SL)) begin bad++; $display("FAIL wd_rewait cyc=%0d got=%0b exp=%0b", c, bus.dbg_gnt, (c == SL)); end
      step();
    end
`else
    for (int c = 0; c < 4; c++) begin
      #2;
      total += 1;
      if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL wd_busy_gnt cyc=%0d got=%0b exp=0", c, bus.dbg_gnt); end
      step();
    end
    bus.cpu_req = 1'b0;
    #2;
    total += 1;
    if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL wd_idle_gnt got=%0b exp=1", bus.dbg_gnt); end
    step();
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
`ifdef ARB_STARVE_GUARD_EN
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0062;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010;
    step();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    // the cycle holding the reset pulse counts as wait cycle 0
    for (int c = 0; c <= SL; c++) begin
      if (c == 0) #1; else #2;
      total += 1;
      if (bus.dbg_gnt !== (c == SL)) begin bad++; $display("FAIL rm_wait cyc=%0d got=%0b exp=%0b", c, bus.dbg_gnt, (c == SL)); end
      step();
    end
    idle_inputs();
`endif
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0020;
    step();
    idle_inputs();
    #1;
    total += 1;
    if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL rm_rvalid_pre got=%0b exp=1", bus.dbg_rvalid); end
    rst = 1'b0;
    #1;
    total += 2;
    if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid got=%0b exp=0", bus.dbg_rvalid); end
    if (bus.dbg_rdata !== 16'h0000) begin bad++; $display("FAIL rm_rdata got=%h exp=0000", bus.dbg_rdata); end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    bit          c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    bit          prev_gnt, prev_stall, exp_rv, forced, e_gnt, e_stall, e_we;
    logic [15:0] exp_rd, e_addr, e_wdata;
    int          waited, pct;
    do_reset();
    c_req = 0; c_we = 0; d_req = 0; d_we = 0;
    c_addr = '0; c_wdata = '0; d_addr = '0; d_wdata = '0;
    prev_gnt = 0; prev_stall = 0; exp_rv = 0; exp_rd = '0; waited = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      pct = (cyc < 300) ? 95 : 50;
      if (!prev_stall) begin
        c_req   = ($urandom_range(0, 99) < pct);
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = 16'($urandom_range(0, 255));
        c_wdata = 16'($urandom);
      end
      if (!d_req || prev_gnt) begin
        d_req   = ($urandom_range(0, 99) < 40);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        d_req = 0;
      end
      bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wdata;
      bus.dbg_req = d_req; bus.dbg_we = d_we; bus.dbg_addr = d_addr; bus.dbg_wdata = d_wdata;

      // reference: debug is owed a slot once it has waited STARVE_LIMIT cycles
`ifdef ARB_STARVE_GUARD_EN
      forced = (waited >= SL);
`else
      forced = 1'b0;
`endif
      e_gnt   = d_req && (!c_req || forced);
      e_stall = c_req && d_req && forced;
      e_addr  = e_gnt ? d_addr : c_addr;
      e_wdata = e_gnt ? d_wdata : c_wdata;
      e_we    = e_gnt ? d_we : (c_req && c_we);

      #2;
      total += 6;
      if (bus.dbg_rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%0b exp=%0b", cyc, bus.dbg_rvalid, exp_rv); end
      if (bus.dbg_rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.dbg_rdata, exp_rd); end
      if (bus.dbg_gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%0b exp=%0b", cyc, bus.dbg_gnt, e_gnt); end
      if (bus.cpu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, bus.cpu_stall, e_stall); end
      if (bus.ram_we !== e_we) begin bad++; $display("FAIL rnd_ram_we cyc=%0d got=%0b exp=%0b", cyc, bus.ram_we, e_we); end
      if (bus.ram_addr !== e_addr) begin bad++; $display("FAIL rnd_ram_addr cyc=%0d got=%h exp=%h", cyc, bus.ram_addr, e_addr); end
      total += 1;
      if (bus.cpu_rdata !== shadow[e_addr[7:0]]) begin bad++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", cyc, bus.cpu_rdata, shadow[e_addr[7:0]]); end
      if (e_we) begin
        total += 1;
        if (bus.ram_wdata !== e_wdata) begin bad++; $display("FAIL rnd_ram_wdata cyc=%0d got=%h exp=%h", cyc, bus.ram_wdata, e_wdata); end
      end

      if (e_gnt && !d_we) begin
        exp_rv = 1'b1;
        exp_rd = shadow[d_addr[7:0]];
      end else begin
        exp_rv = 1'b0;
      end
      if (e_we) shadow[e_addr[7:0]] = e_wdata;
      waited     = (d_req && !e_gnt) ? waited + 1 : 0;
      prev_gnt   = e_gnt;
      prev_stall = e_stall;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_write();
    test_dbg_read();
    test_starvation();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-RAM port (address, write data, write enable, read data) between the pipeline MEM stage and a debug/loader requester. The MEM stage has priority and sees zero added latency. The debug port is served in idle cycles. A starvation guard forces one debug slot by stalling the pipeline for one cycle. The block sits between MEM stage and the data RAM; the MEM stage drives its address/data/write-enable into the cpu side.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- STARVE_LIMIT, 8, debug wait cycles before a forced slot; legal range 1..255

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; 0 clears all state immediately
- cpu_req  in  1  MEM stage access this cycle (read or write)
- cpu_we  in  1  MEM stage write enable
- cpu_addr  in  AW  MEM stage address (ALU result)
- cpu_wdata  in  DW  MEM stage write data
- cpu_rdata  out  DW  read data to MEM stage (combinational from ram_rdata)
- cpu_stall  out  1  MEM stage must hold and repeat its access next cycle
- dbg_req  in  1  debug access request; held with addr/we/wdata stable until dbg_gnt
- dbg_we  in  1  debug write enable
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  dbg_rdata valid (one cycle after a granted read)
- dbg_rdata  out  DW  registered debug read data
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable (RAM writes on clk rising edge, reads combinationally)
- ram_rdata  in  DW  RAM read data

## Operation
- State: wait counter cnt (width $clog2(STARVE_LIMIT+1)), force flag force_q, dbg_rdata register, dbg_rvalid register.
- Owner selection (combinational):
  - DBG if dbg_req && (!cpu_req || force_q).
  - Otherwise CPU.
- dbg_gnt = owner==DBG.
- cpu_stall = cpu_req && force_q && dbg_req.
- RAM mux:
  - Owner DBG: ram_addr/ram_wdata from dbg_*; ram_we = dbg_we.
  - Owner CPU: ram_addr/ram_wdata from cpu_*; ram_we = cpu_req && cpu_we.
  - ram_we is never asserted for a stalled cpu write.
- cpu_rdata = ram_rdata always; it is meaningless to the MEM stage when cpu_stall=1.
- cnt update: if dbg_req && !dbg_gnt, then cnt <= cnt+1; else cnt <= 0.
- force_q update: force_q <= dbg_req && !dbg_gnt && (cnt == STARVE_LIMIT-1).
- Forced-slot behaviour:
  - force_q=1 and dbg_req=1: debug granted, CPU stalled if requesting, force_q clears next cycle.
  - force_q=1 and dbg_req=0 (request withdrawn): no grant, no stall, force_q and cnt clear.
- Debug read capture: on dbg_gnt && !dbg_we, dbg_rdata <= ram_rdata and dbg_rvalid <= 1. Otherwise dbg_rvalid <= 0 and dbg_rdata holds.
- Debug writes produce no dbg_rvalid.
- Simultaneous cpu_req and dbg_req with force_q=0: CPU wins, debug waits.

## Timing
- Reset values: cnt=0, force_q=0, dbg_rvalid=0, dbg_rdata=0.
- Combinational outputs during reset with all requests low: dbg_gnt=0, cpu_stall=0, ram_we=0, ram_addr=cpu_addr.
- CPU path: zero-cycle latency, purely combinational mux.
- Debug grant is same-cycle. Read data is available the cycle after grant (dbg_rvalid pulse, 1 cycle).
- Worst-case debug wait with continuous cpu_req: STARVE_LIMIT cycles. The grant comes in cycle STARVE_LIMIT, counting from the first request cycle as 0.
- cpu_stall lasts at most 1 cycle per forced slot. The next forced slot is at least STARVE_LIMIT+1 cycles later.
- Reset asserted mid-wait or mid-read: state clears asynchronously; an in-flight dbg_rvalid is dropped.

## Configuration
- ARB_STARVE_GUARD_EN defined: starvation guard as described.
- ARB_STARVE_GUARD_EN undefined:
  - cnt and force_q are not implemented; cpu_stall is tied 0.
  - Strict CPU priority: debug is granted only when cpu_req=0 and may starve indefinitely.
  - STARVE_LIMIT is ignored.

## Test plan
- Idle CPU, debug read at addr 0x0010 (RAM holds 0xBEEF): dbg_gnt=1 same cycle, next cycle dbg_rvalid=1, dbg_rdata=0xBEEF, then dbg_rvalid=0.
- CPU write 0x1234 to 0x0020 while dbg_req idle: ram_we=1, ram_addr=0x0020, ram_wdata=0x1234, cpu_stall=0.
- Continuous cpu_req, dbg write 0x5555 to 0x0030 from cycle 0, STARVE_LIMIT=8:
  - Cycles 0-7: dbg_gnt=0.
  - Cycle 8: dbg_gnt=1, cpu_stall=1, ram_addr=0x0030, ram_we=1.
  - Cycle 9: cpu_stall=0.
- Same as above but dbg_req dropped in cycle 8: no grant, cpu_stall=0, cnt=0 next cycle.
- Reset (rst=0) asserted one cycle into a debug wait and during a dbg_rvalid cycle: dbg_rvalid=0 immediately, cnt=0; the wait restarts from 0 after release.
- Build without ARB_STARVE_GUARD_EN, continuous cpu_req for 50 cycles with dbg_req=1: dbg_gnt=0 and cpu_stall=0 throughout.
